// File: rtl/cpu_program_driver.sv
// Program driver for the lab CPU: fetches instruction words from a synchronous-read
// program memory and hands them one at a time to the CPU's load/start/wait handshake.
module cpu_program_driver #(
   parameter int          ADDR_W    = 4,
   parameter logic [15:0] HALT_WORD = 16'hE000,
   parameter logic [7:0]  TIMEOUT   = 8'd255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       cpu_in,
   output logic              cpu_load,
   output logic              cpu_s,
   input  logic              cpu_w,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   issued
);

   typedef enum logic [3:0] {
      IDLE, FETCH, CAPTURE, ISSUE, START, WAIT_BUSY, WAIT_DONE, DONE, ERR
   } state_t;

   localparam logic [ADDR_W:0]   CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] PC_ONE  = 1;

   state_t              state, state_nxt;
   logic [7:0]          tmo_cnt, tmo_nxt;
   logic [ADDR_W-1:0]   pc_nxt;
   logic [ADDR_W:0]     issued_nxt;
   logic [ADDR_W:0]     pc_plus1;
   logic [15:0]         cpu_in_nxt;
   logic                tmo_hit;

   assign pc_plus1 = {1'b0, pc} + CNT_ONE;
   assign tmo_hit  = (tmo_cnt + 8'd1) == TIMEOUT;

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      issued_nxt = issued;
      cpu_in_nxt = cpu_in;
      tmo_nxt    = tmo_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               if (prog_len == '0) begin
                  state_nxt = DONE;
               end else if (cpu_w) begin
                  state_nxt  = FETCH;
                  pc_nxt     = '0;
                  issued_nxt = '0;
               end
            end
         end
         FETCH:   state_nxt = CAPTURE;
         CAPTURE: begin
            if (mem_rdata == HALT_WORD) begin
               state_nxt = DONE;
            end else begin
               cpu_in_nxt = mem_rdata;
               state_nxt  = ISSUE;
            end
         end
         // issued counts up together with the start pulse it belongs to
         ISSUE: begin
            state_nxt  = START;
            issued_nxt = issued + CNT_ONE;
         end
         START: begin
            state_nxt = WAIT_BUSY;
            tmo_nxt   = '0;
         end
         WAIT_BUSY: begin
            if (!cpu_w) begin
               state_nxt = WAIT_DONE;
               tmo_nxt   = '0;
            end else if (tmo_hit) begin
               state_nxt = ERR;
               tmo_nxt   = TIMEOUT;
            end else begin
               tmo_nxt = tmo_cnt + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (cpu_w) begin
               if (pc_plus1 == prog_len) begin
                  state_nxt = DONE;
               end else begin
                  pc_nxt    = pc + PC_ONE;
                  state_nxt = FETCH;
               end
            end else if (tmo_hit) begin
               state_nxt = ERR;
               tmo_nxt   = TIMEOUT;
            end else begin
               tmo_nxt = tmo_cnt + 8'd1;
            end
         end
         DONE: begin
            if (!start) state_nxt = IDLE;
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every one of them is a flop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tmo_cnt  <= '0;
         pc       <= '0;
         issued   <= '0;
         cpu_in   <= '0;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
         cpu_load <= 1'b0;
         cpu_s    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         tmo_cnt  <= tmo_nxt;
         pc       <= pc_nxt;
         issued   <= issued_nxt;
         cpu_in   <= cpu_in_nxt;
         if (state_nxt == FETCH) mem_addr <= pc_nxt;
         mem_rd   <= (state_nxt == FETCH);
         cpu_load <= (state_nxt == ISSUE);
         cpu_s    <= (state_nxt == START);
         busy     <= (state_nxt inside {FETCH, CAPTURE, ISSUE, START, WAIT_BUSY, WAIT_DONE});
         done     <= (state_nxt == DONE);
         err      <= (state_nxt == ERR);
      end
   end

endmodule

// File: doc/cpu_program_driver.md
Name: cpu_program_driver

Overview:
- Drives instructions into the lab CPU through its instruction-register handshake: `cpu_in`/`cpu_load` to latch a word, `cpu_s` to start execution, `cpu_w` as the CPU's wait/ready indication.
- Fetches 16-bit instruction words in order from a synchronous-read program memory, issues each one, and waits for the CPU to finish it before fetching the next.
- Sits between program ROM/RAM and the CPU top level; replaces manual switch/key entry on the board and in benches.

Parameters:
- ADDR_W, 4: program memory address width; max program length 2^ADDR_W.
- HALT_WORD, 16'hE000: instruction word that ends the run without being issued.
- TIMEOUT, 255: max cycles spent in either CPU wait state before error; counter is 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request to run the program from address 0.
- prog_len  input  ADDR_W+1  number of words to execute (0..2^ADDR_W).
- mem_addr  output  ADDR_W  program memory address.
- mem_rd  output  1  read strobe; data is valid on `mem_rdata` exactly one cycle later.
- mem_rdata  input  16  program memory read data.
- cpu_in  output  16  instruction word to the CPU; held stable between issues.
- cpu_load  output  1  one-cycle instruction-register load pulse.
- cpu_s  output  1  one-cycle CPU start pulse.
- cpu_w  input  1  CPU is in its wait state (idle, ready for a new instruction).
- busy  output  1  run in progress.
- done  output  1  run completed normally.
- err  output  1  CPU handshake timeout; sticky.
- pc  output  ADDR_W  address of the current instruction.
- issued  output  ADDR_W+1  count of instructions started this run.

Behaviour:
- All outputs are registered (Moore).
- On reset low: state = IDLE, all outputs = 0 (including `cpu_in`, `pc`, `issued`), timeout counter = 0.
- States: IDLE, FETCH, CAPTURE, ISSUE, START, WAIT_BUSY, WAIT_DONE, DONE, ERR.
- IDLE:
  - If `start`=1 and `prog_len`=0, go to DONE.
  - Else if `start`=1 and `cpu_w`=1, go to FETCH with `pc`=0, `issued`=0, `busy`=1.
  - If `start`=1 and `cpu_w`=0, stay in IDLE and do not start.
- FETCH: `mem_rd`=1, `mem_addr`=`pc`; next state CAPTURE.
- CAPTURE:
  - Sample `mem_rdata`.
  - If it equals HALT_WORD, go to DONE; `cpu_in` is unchanged and the word is not issued.
  - Otherwise `cpu_in` <= `mem_rdata` and go to ISSUE.
- ISSUE: `cpu_load`=1 for exactly one cycle; next state START.
- START: `cpu_s`=1 for exactly one cycle; `issued` increments; timeout counter clears; next state WAIT_BUSY.
- WAIT_BUSY: wait for `cpu_w`=0, which acknowledges the start, then go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE: wait for `cpu_w`=1.
  - If `pc`+1 = `prog_len`, go to DONE.
  - Otherwise `pc` increments and go to FETCH.
- Timeout: in WAIT_BUSY or WAIT_DONE, the counter increments every cycle. When it reaches TIMEOUT, go to ERR: `err`=1, `busy`=0.
- ERR holds until reset; `start` has no effect in ERR.
- DONE: `done`=1, `busy`=0. Hold until `start`=0, then go to IDLE with `done` cleared the same cycle the state changes.
- `start` deasserted mid-run: the run continues to completion; no abort.
- Minimum latency per instruction: FETCH to START is 4 cycles, plus CPU execution time.
- `cpu_load` and `cpu_s` are never asserted in the same cycle.
- `cpu_in` changes only on the CAPTURE→ISSUE transition.
- Reset asserted mid-operation: everything returns to reset values immediately, including dropping any `cpu_load`/`cpu_s` pulse.
- `pc` never exceeds `prog_len`-1. At `prog_len` = 2^ADDR_W, the last address is all-ones and no wrap occurs.

Test Plan:
- Basic issue sequence:
  - Stimulus: memory = {D101, D202, A0A1}, `prog_len`=3, model CPU holds `w` low for 3 cycles after `s`, then raise `start`.
  - Required: exactly 3 `cpu_load` pulses carrying those words in order, each followed the next cycle by one `cpu_s`; `issued`=3; `done`=1; `busy`=0.
- Halt word:
  - Stimulus: memory = {D101, E000, D202}, `prog_len`=3.
  - Required: only D101 is issued; `done`=1 with `pc`=1, `issued`=1; `cpu_in` stays D101.
- Timeout:
  - Stimulus: model CPU never drops `w` after `s`.
  - Required: `err`=1 exactly TIMEOUT cycles after the WAIT_BUSY entry, `busy`=0, no further pulses; then `start` toggled → remains in ERR; reset low → all outputs 0.
- Start gating:
  - Stimulus: `start`=1 while `cpu_w`=0, later raise `cpu_w`.
  - Required: no `mem_rd` while `cpu_w`=0; the first FETCH occurs the cycle after `cpu_w` rises.
  - Stimulus: `prog_len`=0.
  - Required: `done`=1 one cycle after `start`, with zero `mem_rd`.
- Full depth, done release, reset:
  - Stimulus: `prog_len`=16, ADDR_W=4.
  - Required: addresses 0..15 fetched once each with no wrap; `done` stays high while `start`=1 and clears the cycle after `start`=0.
  - Stimulus: reset asserted during ISSUE.
  - Required: `cpu_load` drops immediately and all outputs are 0.
